// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// FSM state encodings are plain constants so legacy tools can consume them.
package clk_div_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    localparam int unsigned DIV_MIN = 2;

    // Number of cycles clk_o is high within one divided period.
    function automatic int unsigned half_len(input int unsigned n);
        return n / 2;
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter for the divider: produces the registered divided clock,
// the one-cycle enable pulse and the period-wrap indication.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             cnt_en_i,
    input  logic             out_en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] next_div_i,
    output logic             wrap_o,
    output logic             clk_o,
    output logic             clk_en_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_next;
    logic             clk_q, clk_d;
    logic             en_q, en_d;

    // Outputs are computed from the next count and next ratio so that the
    // registered clk_o/clk_en_o line up with the cycle that cnt describes.
    always_comb begin
        wrap_o    = cnt_en_i && (cnt_q == div_i - 1'b1);
        cnt_d     = '0;
        if (cnt_en_i && out_en_i && !wrap_o) begin
            cnt_d = cnt_q + 1'b1;
        end
        half_next = DIV_W'(half_len(32'(next_div_i)));
        clk_d     = out_en_i && (cnt_d < half_next);
        en_d      = out_en_i && (cnt_d == next_div_i - 1'b1);
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
            en_q  <= en_d;
        end
    end

    assign clk_o    = clk_q;
    assign clk_en_o = en_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: start/stop FSM, divide-ratio handshake and the
// ratio currently in effect; ratio changes while running land on a period boundary.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic [DIV_W-1:0] cur_div,
    output logic             clk_o,
    output logic             clk_en_o,
    output logic             busy
);

    // Handshake: the requester holds cfg_valid with a stable cfg_div until
    // cfg_ack; cfg_valid is ignored in the ack cycle and while a change is pending.
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             new_req, req_bad, req_ok;
    logic             wrap;

    always_comb begin
        new_req    = cfg_valid && !ack_q && !pend_q;
        req_bad    = new_req && (cfg_div < DIV_W'(DIV_MIN));
        req_ok     = new_req && !req_bad;
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        ack_d      = req_bad;
        err_d      = req_bad;

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    cur_div_d = cfg_div;
                    ack_d     = 1'b1;
                end
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_STOPPING: begin
                if (state_q == ST_RUN) begin
                    if (!run) state_d = ST_STOPPING;
                end else if (run) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                end
                // A request arriving on the boundary cycle itself is applied
                // directly, so a pending change never survives into IDLE.
                if (wrap) begin
                    if (pend_q) begin
                        cur_div_d = pend_div_q;
                        ack_d     = 1'b1;
                        pend_d    = 1'b0;
                    end else if (req_ok) begin
                        cur_div_d = cfg_div;
                        ack_d     = 1'b1;
                    end
                end else if (req_ok) begin
                    pend_d     = 1'b1;
                    pend_div_d = cfg_div;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_div_q  <= DIV_W'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    clk_div_counter #(
        .DIV_W(DIV_W)
    ) u_counter (
        .clk_i     (clk_i),
        .rst       (rst),
        .cnt_en_i  (state_q != ST_IDLE),
        .out_en_i  (state_d != ST_IDLE),
        .div_i     (cur_div_q),
        .next_div_i(cur_div_d),
        .wrap_o    (wrap),
        .clk_o     (clk_o),
        .clk_en_o  (clk_en_o)
    );

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;
    assign cur_div = cur_div_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: expected {clk_o, clk_en_o} per cycle is
// queued from the divide ratio and popped against the DUT each cycle.
module tb_clk_div_ctrl;

    localparam int DIV_W = 8;

    logic             clk_i = 1'b0;
    logic             rst;
    logic             run;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;
    logic [DIV_W-1:0] cur_div;
    logic             clk_o;
    logic             clk_en_o;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    clk_div_ctrl #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_i    (clk_i),
        .rst      (rst),
        .run      (run),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ack  (cfg_ack),
        .cfg_err  (cfg_err),
        .cur_div  (cur_div),
        .clk_o    (clk_o),
        .clk_en_o (clk_en_o),
        .busy     (busy)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue expected {clk_o, clk_en_o} for `cycles` cycles of ratio n from cnt=0.
    task automatic push_wave(input int n, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int c;
            c = i % n;
            exp_q.push_back({c < n / 2, c == n - 1});
        end
    endtask

    // Compare the current cycle against the queue head, then advance one cycle.
    task automatic check_wave(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            logic [1:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL wave_underflow observed=empty expected=entry");
            end else begin
                e = exp_q.pop_front();
                check("wave", 32'({clk_o, clk_en_o}), 32'(e));
            end
            cyc();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_clk_o"}, 32'(clk_o), 32'd0);
        check({tag, "_clk_en"}, 32'(clk_en_o), 32'd0);
        check({tag, "_ack"}, 32'(cfg_ack), 32'd0);
        check({tag, "_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cur_div"}, 32'(cur_div), 32'd4);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        repeat (3) cyc();
        rst = 1'b0;
        check_reset_values("reset");

        // Default N=4 start-up: 1100 with enable on the last low cycle.
        run = 1'b1;
        cyc();
        check("run_busy", 32'(busy), 32'd1);
        push_wave(4, 12);
        check_wave(12);

        // Illegal ratio (0 or 1) is rejected without disturbing the waveform.
        push_wave(4, 8);
        cfg_valid = 1'b1;
        cfg_div = DIV_W'($urandom_range(0, 1));
        check_wave(1);
        check("bad_ack", 32'(cfg_ack), 32'd1);
        check("bad_err", 32'(cfg_err), 32'd1);
        check("bad_cur_div", 32'(cur_div), 32'd4);
        cfg_valid = 1'b0;
        check_wave(1);
        check("bad_ack_once", 32'(cfg_ack), 32'd0);
        check_wave(6);

        // Change to N=6 requested at cnt=1 takes effect only at the boundary.
        push_wave(4, 4);
        check_wave(1);
        cfg_valid = 1'b1;
        cfg_div = 8'd6;
        check_wave(1);
        check("pend_cur_div_c2", 32'(cur_div), 32'd4);
        check("pend_ack_c2", 32'(cfg_ack), 32'd0);
        check_wave(1);
        check("pend_cur_div_c3", 32'(cur_div), 32'd4);
        check("pend_ack_c3", 32'(cfg_ack), 32'd0);
        check_wave(1);
        check("apply6_cur_div", 32'(cur_div), 32'd6);
        check("apply6_ack", 32'(cfg_ack), 32'd1);
        check("apply6_err", 32'(cfg_err), 32'd0);
        cfg_valid = 1'b0;
        push_wave(6, 12);
        check_wave(12);

        // Back to N=4 through the same boundary path.
        cfg_valid = 1'b1;
        cfg_div = 8'd4;
        push_wave(6, 6);
        check_wave(6);
        check("apply4_cur_div", 32'(cur_div), 32'd4);
        check("apply4_ack", 32'(cfg_ack), 32'd1);
        cfg_valid = 1'b0;

        // Drop run at cnt=1: the period completes, then IDLE.
        push_wave(4, 4);
        check_wave(1);
        run = 1'b0;
        check_wave(1);
        check("stopping_busy", 32'(busy), 32'd1);
        check_wave(2);
        check("stopped_clk_o", 32'(clk_o), 32'd0);
        check("stopped_clk_en", 32'(clk_en_o), 32'd0);
        check("stopped_busy", 32'(busy), 32'd0);
        cyc();
        check("idle_clk_o", 32'(clk_o), 32'd0);

        // Drop run at cnt=1 and re-assert at cnt=2: no gap in the waveform.
        run = 1'b1;
        cyc();
        push_wave(4, 12);
        check_wave(1);
        run = 1'b0;
        check_wave(1);
        run = 1'b1;
        check_wave(10);
        check("resume_busy", 32'(busy), 32'd1);

        // Stop, then program N=3 in IDLE and restart.
        run = 1'b0;
        push_wave(4, 4);
        check_wave(4);
        check("idle2_busy", 32'(busy), 32'd0);
        cfg_valid = 1'b1;
        cfg_div = 8'd3;
        cyc();
        check("idle_ack", 32'(cfg_ack), 32'd1);
        check("idle_err", 32'(cfg_err), 32'd0);
        check("idle_cur_div", 32'(cur_div), 32'd3);
        cfg_valid = 1'b0;
        cyc();
        check("idle_ack_once", 32'(cfg_ack), 32'd0);
        run = 1'b1;
        cyc();
        push_wave(3, 9);
        check_wave(9);

        // run and cfg_valid together in IDLE: RUN starts with the new ratio.
        run = 1'b0;
        push_wave(3, 3);
        check_wave(3);
        run = 1'b1;
        cfg_valid = 1'b1;
        cfg_div = 8'd5;
        cyc();
        check("simul_ack", 32'(cfg_ack), 32'd1);
        check("simul_cur_div", 32'(cur_div), 32'd5);
        cfg_valid = 1'b0;
        push_wave(5, 10);
        check_wave(10);

        // Reset with a change pending: everything back to reset, no late ack.
        cfg_valid = 1'b1;
        cfg_div = 8'd7;
        push_wave(5, 2);
        check_wave(2);
        rst = 1'b1;
        run = 1'b0;
        cfg_valid = 1'b0;
        cyc();
        check_reset_values("midrst");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("post_rst_ack", 32'(cfg_ack), 32'd0);
            check("post_rst_cur_div", 32'(cur_div), 32'd4);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable clock-divider controller that sequences a local divided clock, clk_o, and a matching clock-enable pulse, clk_en_o, from clk_i.
- Divide ratio changes use a valid/ack handshake. A change during operation is applied only at a period boundary, so clk_o never produces a runt pulse.
- Start and stop are sequenced through a small state machine.
- The block sits beside locally generated LUT/FF clocks and is the single configuration point for their divide ratio.

Parameters:
- DIV_W, 8, width of the divide ratio N and the internal counter.
- DEFAULT_DIV, 4, divide ratio loaded at reset. Must satisfy 2 <= DEFAULT_DIV <= 2^DIV_W-1.

Ports:
- clk_i  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = generate clock, 0 = stop at the next period boundary.
- cfg_valid  in  1  new-ratio request; held by the requester until cfg_ack.
- cfg_div  in  DIV_W  requested ratio N; stable while cfg_valid=1.
- cfg_ack  out  1  registered one-cycle pulse; request consumed.
- cfg_err  out  1  registered one-cycle pulse, coincident with cfg_ack; request rejected.
- cur_div  out  DIV_W  ratio currently in effect.
- clk_o  out  1  registered divided clock.
- clk_en_o  out  1  registered one-cycle pulse, once per divided period.
- busy  out  1  1 in RUN or STOPPING.

Behaviour:
- Reset values: cur_div=DEFAULT_DIV; clk_o, clk_en_o, cfg_ack, cfg_err and busy all 0; counter cnt=0; state IDLE; no pending request.
- Reset during any state discards a pending request and issues no cfg_ack.
- States:
  - IDLE: clk_o=0, cnt held at 0. run=1 -> RUN with cnt=0.
  - RUN: cnt counts 0..N-1 and wraps; N=cur_div. run=0 -> STOPPING.
  - STOPPING: keeps counting. At cnt==N-1 -> IDLE. run re-asserted before the boundary -> back to RUN, with no gap in counting.
- clk_o in RUN/STOPPING: registered, so clk_o=1 exactly during cycles where cnt < N/2 (integer division).
  - High for N/2 cycles, low for N-N/2 cycles.
  - Example N=4: 1100 repeating. N=3: 100 repeating.
  - clk_o is 0 in the cycle after returning to IDLE.
- clk_en_o=1 during the cycle where cnt==N-1, in RUN/STOPPING only.
- Config handshake:
  - cfg_div < 2 is rejected: cfg_ack=1 and cfg_err=1 the next cycle; cur_div unchanged.
  - In IDLE, a valid request sets cur_div<=cfg_div, and cfg_ack pulses the next cycle.
  - In RUN/STOPPING, the request is latched as pending. At the boundary (cnt==N-1), cnt<=0 and cur_div<=pending value; cfg_ack pulses in that same first cycle of the new period.
- cfg_valid is ignored in the cycle cfg_ack=1. Any request sampled after that cycle is a new request.
- Only one request is pending at a time. cfg_valid/cfg_div changes while pending are ignored (protocol violation, no effect).
- Simultaneous events:
  - Pending change plus STOPPING boundary: the new ratio is applied, cfg_ack pulses, and the state goes to IDLE.
  - run=1 and cfg_valid=1 in IDLE on the same cycle: the new ratio is applied first, and RUN starts with it.
- Counter width: DIV_W. A shrinking N at a boundary is safe because cnt restarts at 0.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN, STOPPING};
  - constant DIV_MIN=2;
  - function for the high-phase length N/2.
- One sub-module, clk_div_counter: holds cnt, and generates clk_o, clk_en_o and the wrap indication from N and an enable.
- clk_div_ctrl holds the FSM, the handshake and cur_div.

Test Plan:
1. Reset, run=1 with default N=4 -> clk_o pattern 1100 repeating, starting the cycle after RUN entry; clk_en_o pulses every 4th cycle, aligned with the last low cycle.
2. In IDLE, cfg_div=3 -> cfg_ack 1 cycle later, cfg_err=0, cur_div=3; then run=1 -> clk_o 100 repeating.
3. While running at N=4 with cnt=1, request cfg_div=6 -> no change until cnt==3; next cycle cur_div=6 and cfg_ack=1; clk_o 111000 thereafter with no runt pulse.
4. cfg_div=1 in RUN -> cfg_ack=1 and cfg_err=1 the next cycle; cur_div stays 4; waveform undisturbed.
5. Drop run at cnt=1 (N=4) -> period completes, clk_o=0 and busy=0 after the boundary. A variant that re-asserts run at cnt=2 -> continuous 1100 with no gap.
6. Assert rst mid-period with a change pending -> next cycle all outputs at reset values, cur_div=DEFAULT_DIV, no cfg_ack ever issued for the lost request.
